// File: rtl/cc_error_checker_if.sv
// Byte-stream bus carrying the aligned TS bytes into the continuity checker.
// The source drives bytes through the master modport, the checker receives them
// through the slave modport.
interface cc_error_checker_if;
  logic [7:0] r_data;
  logic       r_valid;
  logic       sync;

  modport master (output r_data, output r_valid, output sync);
  modport slave  (input  r_data, input  r_valid, input  sync);
endinterface

// File: rtl/cc_error_checker.sv
// Continuity-counter checker for one TS stream.
// Parses the 4-byte TS header and compares the received CC with the expected CC
// from the generator. Each packet is classified as OK, accepted duplicate or CC
// error. Errors are accumulated per measurement window in saturating counters.
// Optional macro CC_DISCONT_EN: parse the adaptation-field flags byte and
// suppress the CC error when the discontinuity_indicator is set.
module cc_error_checker #(
  parameter int ERR_W     = 16,
  parameter bit SKIP_NULL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  cc_error_checker_if.slave    bus,
  input  logic [7:0]           cc_expected,
  input  logic                 window_tick,
  output logic                 pkt_checked,
  output logic                 cc_err,
  output logic                 cc_dup,
  output logic [3:0]           cc_rx,
  output logic [ERR_W-1:0]     err_count,
  output logic [ERR_W-1:0]     err_window
);

`ifdef CC_DISCONT_EN
  typedef enum logic [2:0] {IDLE, B2, B3, B4, DECIDE, AF_LEN, AF_FLG} state_t;
`else
  typedef enum logic [2:0] {IDLE, B2, B3, B4, DECIDE} state_t;
`endif

  state_t      state;
  state_t      next_state;
  logic        tei;
  logic [12:0] pid;
  logic [1:0]  afc;
  logic        dup_seen;
  logic        dup_set;
  logic        dup_clr;
  logic        skip;
  logic [3:0]  cc_prev;
  logic [ERR_W:0]   count_inc;
  logic [ERR_W-1:0] count_sat;
  logic        unused_expected_bits;
`ifdef CC_DISCONT_EN
  logic        di;
`endif

  assign unused_expected_bits = &{1'b0, cc_expected[7:5]};

  // Packets with transport errors, no payload, or null PID are not CC-checked.
  assign skip    = tei | ~afc[0] | (SKIP_NULL && (pid == 13'h1FFF));
  assign cc_prev = cc_expected[3:0] - 4'd1;

  // Header parser state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic and the single-cycle evaluation pulses while in DECIDE.
  // A sync during DECIDE still lets this packet's evaluation complete, since it
  // already happens in that same cycle.
  always_comb begin
    next_state  = state;
    pkt_checked = 1'b0;
    cc_err      = 1'b0;
    cc_dup      = 1'b0;
    dup_set     = 1'b0;
    dup_clr     = 1'b0;

    if (bus.r_valid && bus.sync) begin
      next_state = B2;
    end else begin
      case (state)
        IDLE:   next_state = IDLE;
        B2:     if (bus.r_valid) next_state = B3;
        B3:     if (bus.r_valid) next_state = B4;
`ifdef CC_DISCONT_EN
        B4:     if (bus.r_valid) next_state = (bus.r_data[5:4] == 2'b11) ? AF_LEN : DECIDE;
        AF_LEN: if (bus.r_valid) next_state = (bus.r_data == 8'd0) ? DECIDE : AF_FLG;
        AF_FLG: if (bus.r_valid) next_state = DECIDE;
`else
        B4:     if (bus.r_valid) next_state = DECIDE;
`endif
        DECIDE: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end

    if (state == DECIDE && !skip) begin
      pkt_checked = 1'b1;
      if (!cc_expected[4]) begin
        // First packet of the stream: nothing to compare against yet.
      end else if (cc_rx == cc_expected[3:0]) begin
        dup_clr = 1'b1;
      end else if (cc_rx == cc_prev && !dup_seen) begin
        cc_dup  = 1'b1;
        dup_set = 1'b1;
      end else begin
        dup_clr = 1'b1;
`ifdef CC_DISCONT_EN
        cc_err  = ~di;
`else
        cc_err  = 1'b1;
`endif
      end
    end
  end

  // Capture header fields as their bytes are accepted; sync bytes never load fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tei   <= 1'b0;
      pid   <= 13'd0;
      afc   <= 2'b00;
      cc_rx <= 4'd0;
`ifdef CC_DISCONT_EN
      di    <= 1'b0;
`endif
    end else if (bus.r_valid && !bus.sync) begin
      case (state)
        B2: begin
          tei       <= bus.r_data[7];
          pid[12:8] <= bus.r_data[4:0];
        end
        B3: pid[7:0] <= bus.r_data;
        B4: begin
          afc   <= bus.r_data[5:4];
          cc_rx <= bus.r_data[3:0];
`ifdef CC_DISCONT_EN
          di    <= 1'b0;
`endif
        end
`ifdef CC_DISCONT_EN
        AF_FLG: di <= bus.r_data[7];
`endif
        default: ;
      endcase
    end
  end

  // Remember an accepted duplicate so a second one in a row is flagged.
  always_ff @(posedge clk) begin
    if (!rst)         dup_seen <= 1'b0;
    else if (dup_set) dup_seen <= 1'b1;
    else if (dup_clr) dup_seen <= 1'b0;
  end

  assign count_inc = {1'b0, err_count} + {{ERR_W{1'b0}}, cc_err};
  assign count_sat = count_inc[ERR_W] ? {ERR_W{1'b1}} : count_inc[ERR_W-1:0];

  // Saturating window error counter; an error coinciding with the tick
  // belongs to the window being closed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count  <= '0;
      err_window <= '0;
    end else if (window_tick) begin
      err_window <= count_sat;
      err_count  <= '0;
    end else begin
      err_count  <= count_sat;
    end
  end

endmodule
